// File: rtl/l2_fifo_ctrl.sv
// rtl/l2_fifo_ctrl.sv - stream FIFO controller around a 16x48 registered-read L2 buffer RAM
module l2_fifo_ctrl #(
  parameter int DATA_W = 48,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W+1:0] count,
  output logic [DATA_W-1:0] ram_data,
  output logic [ADDR_W-1:0] ram_wraddress,
  output logic              ram_wren,
  output logic [ADDR_W-1:0] ram_rdaddress,
  input  logic [DATA_W-1:0] ram_q
);

  localparam logic [ADDR_W:0] RAM_FULL = (ADDR_W+1)'(1 << ADDR_W);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   ram_cnt;
  logic              rd_pend;
  logic [1:0]        buf_cnt;
  logic [DATA_W-1:0] buf0;
  logic [DATA_W-1:0] buf1;
  logic              out_valid_q;

  logic              push;
  logic              pop;
  logic              rd_go;
  logic [1:0]        buf_keep;
  logic [1:0]        buf_cnt_nxt;

  // Handshakes, read issue and RAM port drive; the prefetch window counts the
  // read already in flight so the two-entry buffer can never overflow.
  always_comb begin
    in_ready      = (ram_cnt != RAM_FULL) & ~flush;
    push          = in_valid & in_ready;
    pop           = out_valid_q & out_ready;
    buf_keep      = buf_cnt - {1'b0, pop};
    rd_go         = (ram_cnt != '0)
                  & (({1'b0, buf_keep} + {2'b00, rd_pend}) < 3'd2)
                  & ~flush;
    buf_cnt_nxt   = buf_keep + {1'b0, rd_pend};
    ram_wren      = push & reset_n;
    ram_data      = in_data;
    ram_wraddress = wr_ptr;
    ram_rdaddress = rd_ptr;
    out_valid     = out_valid_q;
    out_data      = buf0;
    count         = {1'b0, ram_cnt}
                  + {{(ADDR_W+1){1'b0}}, rd_pend}
                  + {{ADDR_W{1'b0}}, buf_cnt};
  end

  // Pointers, occupancy and prefetch buffer; reset and flush share one clear path
  // and drop whatever word the RAM is returning this cycle.
  always_ff @(posedge clock) begin
    if (!reset_n || flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      ram_cnt     <= '0;
      rd_pend     <= 1'b0;
      buf_cnt     <= 2'd0;
      buf0        <= '0;
      buf1        <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (rd_go) rd_ptr <= rd_ptr + ADDR_W'(1);
      rd_pend <= rd_go;
      if (push && !rd_go) ram_cnt <= ram_cnt + (ADDR_W+1)'(1);
      else if (!push && rd_go) ram_cnt <= ram_cnt - (ADDR_W+1)'(1);
      buf_cnt     <= buf_cnt_nxt;
      out_valid_q <= (buf_cnt_nxt != 2'd0);
      if (pop && buf_cnt == 2'd2) buf0 <= buf1;
      if (rd_pend) begin
        if (buf_keep == 2'd0) buf0 <= ram_q;
        else buf1 <= ram_q;
      end
    end
  end

endmodule

// File: tb/tb_l2_fifo_ctrl.sv
// tb/tb_l2_fifo_ctrl.sv - randomized scoreboard bench for l2_fifo_ctrl
module tb_l2_fifo_ctrl;
  localparam int DW = 48;
  localparam int AW = 4;

  logic          clock = 1'b0;
  logic          reset_n, flush, in_valid, in_ready, out_valid, out_ready, ram_wren;
  logic [DW-1:0] in_data, out_data, ram_data, ram_q;
  logic [AW+1:0] count;
  logic [AW-1:0] ram_wraddress, ram_rdaddress;

  always #5 clock = ~clock;

  l2_fifo_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count), .ram_data(ram_data), .ram_wraddress(ram_wraddress),
    .ram_wren(ram_wren), .ram_rdaddress(ram_rdaddress), .ram_q(ram_q)
  );

  // Two-port RAM with registered read
  logic [DW-1:0] mem [16];
  always @(posedge clock) begin
    if (ram_wren) mem[ram_wraddress] <= ram_data;
    ram_q <= mem[ram_rdaddress];
  end

  // Reference: an 18-word FIFO where a word reaches the head no earlier than two edges after its push
  typedef struct {
    logic [DW-1:0] d;
    int            t;
  } ent_t;
  ent_t mq[$];
  int now = 0;
  int wcnt = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int popped = 0;
  int dut_acc = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    bit eov, eir, epush, epop;
    #1;
    eov   = (mq.size() > 0) && (mq[0].t <= now - 2);
    eir   = (mq.size() != 18) && !flush;
    epush = reset_n && in_valid && eir;
    epop  = eov && out_ready;
    chk("out_valid", out_valid, eov);
    chk("count", count, mq.size());
    if (eov) chk("out_data", out_data, mq[0].d);
    if (reset_n) chk("in_ready", in_ready, eir);
    chk("ram_wren", ram_wren, epush);
    if (epush) chk("ram_wraddress", ram_wraddress, wcnt);
    if (reset_n && in_valid && in_ready) dut_acc++;
    @(posedge clock);
    now++;
    if (!reset_n || flush) begin
      mq.delete();
      wcnt = 0;
    end else begin
      if (epop) begin
        void'(mq.pop_front());
        popped++;
      end
      if (epush) begin
        mq.push_back('{in_data, now});
        wcnt = (wcnt + 1) % 16;
      end
    end
    @(negedge clock);
  endtask

  task automatic check_reset_outputs(input string tag);
    #1;
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_ram_wren"}, ram_wren, 0);
    chk({tag, "_wraddr"}, ram_wraddress, 0);
    chk({tag, "_rdaddr"}, ram_rdaddress, 0);
  endtask

  initial begin
    logic [63:0] r;
    int cyc;
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 48'hDEAD; out_ready = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check_reset_outputs("reset");
    step();
    reset_n = 1'b1; in_valid = 1'b0;
    step();

    // Single word latency
    in_valid = 1'b1; in_data = 48'h0000_1234_5678;
    step();
    in_valid = 1'b0;
    step();
    step();
    #1;
    chk("single_valid", out_valid, 1);
    chk("single_data", out_data, 48'h0000_1234_5678);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    step();

    // Fill to capacity, then drain in order
    dut_acc = 0;
    for (int k = 1; k <= 20; k++) begin
      in_valid = 1'b1; in_data = DW'(k);
      step();
    end
    in_valid = 1'b0;
    #1;
    chk("fill_accepted", dut_acc, 18);
    chk("fill_count", count, 18);
    chk("fill_in_ready", in_ready, 0);
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) step();

    // Full-rate streaming across pointer wraps
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1; in_data = DW'(1000 + i); out_ready = 1'b1;
      step();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) step();

    // Random traffic with backpressure
    popped = 0;
    cyc = 0;
    while (popped < 1000 && cyc < 10000) begin
      r = {$urandom, $urandom};
      in_valid = 1'($urandom_range(0, 1));
      in_data = r[DW-1:0];
      out_ready = 1'($urandom_range(0, 1));
      step();
      cyc++;
    end
    if (popped < 1000) chk("random_budget", popped, 1000);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 25; k++) step();

    // Flush with five words held and a read in flight
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = DW'(256 + i);
      step();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    #1;
    chk("flush_pre_count", count, 5);
    flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    chk("flush_count", count, 0);
    chk("flush_valid", out_valid, 0);
    in_valid = 1'b1; in_data = 48'hABC;
    step();
    in_valid = 1'b0;
    step();
    step();
    #1;
    chk("flush_first_valid", out_valid, 1);
    chk("flush_first_data", out_data, 48'hABC);
    out_ready = 1'b1;
    step();
    step();

    // Reset with ten words held and a write attempted during reset
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = DW'(512 + i);
      step();
    end
    in_data = 48'hBAD; reset_n = 1'b0;
    step();
    check_reset_outputs("midreset");
    reset_n = 1'b1; in_valid = 1'b1; in_data = 48'h777;
    step();
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
